// File: rtl/return_stack_if.sv
// Purpose : bundles the control-side signals of the return-address stack.
// Ports   : master drives push/pop/err_clr/in and reads the stack status;
//           slave (the stack itself) is the mirror image.
interface return_stack_if #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic                 push;
  logic                 pop;
  logic                 err_clr;
  logic [BIT_WIDTH-1:0] in;
  logic [BIT_WIDTH-1:0] out;
  logic [CW-1:0]        count;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, pop, err_clr, in,
    input  out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, err_clr, in,
    output out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Purpose : LIFO return-address stack; push saves the PC, pop restores it.
// Latency : one clk from push/pop to updated out/count/empty/full; out is
//           combinational from registered state.
// Backpressure: none; a push when full or a pop when empty is refused and
//           latched in the sticky overflow/underflow flags.
// Ports   : clk, rst (async, active-low); bus (slave modport) carries
//           push, pop, err_clr, in -> out, count, empty, full, overflow, underflow.
module return_stack #(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8
) (
  input logic           clk,
  input logic           rst,
  return_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]        r_sp;
  logic [BIT_WIDTH-1:0] r_mem [DEPTH];
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_empty;
  logic                 w_full;
  logic [AW-1:0]        w_top_idx;
  logic                 w_wr_en;
  logic [AW-1:0]        w_wr_idx;
  logic [CW-1:0]        w_sp_nxt;
  logic                 w_ovf_set;
  logic                 w_unf_set;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == CW'(DEPTH));
  // Wraps when empty, but every consumer gates on w_empty first.
  assign w_top_idx = AW'(r_sp - CW'(1));

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = w_top_idx;
    w_sp_nxt  = r_sp;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (bus.push && bus.pop) begin
      // Simultaneous push/pop replaces the top; on an empty stack it
      // degenerates to a plain push and never flags an error.
      w_wr_en = 1'b1;
      if (w_empty) begin
        w_wr_idx = '0;
        w_sp_nxt = CW'(1);
      end
    end else if (bus.push) begin
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_wr_idx = AW'(r_sp);
        w_sp_nxt = r_sp + CW'(1);
      end
    end else if (bus.pop) begin
      if (w_empty) begin
        w_unf_set = 1'b1;
      end else begin
        w_sp_nxt = r_sp - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_sp  <= w_sp_nxt;
      // A new error event in the clearing cycle wins over err_clr.
      r_ovf <= w_ovf_set | (r_ovf & ~bus.err_clr);
      r_unf <= w_unf_set | (r_unf & ~bus.err_clr);
      if (w_wr_en) begin
        r_mem[w_wr_idx] <= bus.in;
      end
    end
  end

  assign bus.out       = w_empty ? '0 : r_mem[w_top_idx];
  assign bus.count     = r_sp;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;
endmodule
